// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch unit.
//   state_e    : sequencer states
//   *_DEF      : default parameter values (instruction width, timeout)
//   sat_inc16  : saturating 16-bit increment for the retire counter
package bitty_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RELEASE,
        HALT,
        ERROR
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bitty_prog_mem.sv
// Program memory: simple dual-port RAM, synchronous write, synchronous read
// (one-cycle latency). Contents are never reset.
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every rising edge
//   rdata  : mem[raddr] from the previous edge
module bitty_prog_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction sequencer driving the bitty_core run/done handshake.
// Holds a host-loaded program memory, walks a PC from 0 to the latched
// program length and presents one instruction at a time with run held
// high until the core reports done.
//   clk, reset          : clock; synchronous active-high reset
//   load_en/addr/data   : program memory write port (only when not busy)
//   prog_len            : instruction count, latched on accepted start
//   start, stop         : begin at PC 0 / halt after current instruction
//   instruction, run    : registered request to the core
//   done                : completion from the core
//   pc, instr_count     : current index, retired count (saturating)
//   busy, halted, error : status
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] instruction,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W:0]   pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [15:0]       count_q, count_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              stop_pend_q, stop_pend_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   len_in;
    logic              idle_like;

    assign idle_like = (state_q == IDLE) || (state_q == HALT) || (state_q == ERROR);
    assign mem_we    = load_en && idle_like;
    assign len_in    = (prog_len > DEPTH) ? DEPTH : prog_len;

    // The read address follows pc_d, so the word for the new PC is already
    // on rdata during the single FETCH cycle.
    bitty_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_d[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        count_d     = count_q;
        tmo_d       = tmo_q;
        stop_pend_d = stop_pend_q;
        run_d       = run_q;
        instr_d     = instr_q;

        case (state_q)
            IDLE, HALT, ERROR: begin
                run_d = 1'b0;
                if (start && !stop) begin
                    len_d       = len_in;
                    pc_d        = '0;
                    count_d     = '0;
                    stop_pend_d = 1'b0;
                    state_d     = (len_in == '0) ? HALT : FETCH;
                end
            end
            FETCH: begin
                if (stop) stop_pend_d = 1'b1;
                instr_d = mem_rdata;
                run_d   = 1'b1;
                tmo_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (stop) stop_pend_d = 1'b1;
                if (done) begin
                    run_d   = 1'b0;
                    pc_d    = pc_q + 1'b1;
                    count_d = sat_inc16(count_q);
                    tmo_d   = '0;
                    state_d = RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    run_d   = 1'b0;
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RELEASE: begin
                if (stop) stop_pend_d = 1'b1;
                // Wait for done to fall so a level-held done is counted once.
                if (!done) begin
                    state_d = (stop_pend_q || stop || pc_q == len_q) ? HALT : FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            stop_pend_q <= 1'b0;
            run_q       <= 1'b0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            stop_pend_q <= stop_pend_d;
            run_q       <= run_d;
            instr_q     <= instr_d;
        end
    end

    assign instruction = instr_q;
    assign run         = run_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign busy        = (state_q == FETCH) || (state_q == ISSUE) || (state_q == RELEASE);
    assign halted      = (state_q == HALT);
    assign error       = (state_q == ERROR);

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench for bitty_fetch_unit: a core model answering the
// run/done handshake, a transaction-level model (retired count, run pulses,
// program image) checked every cycle, and directed scenarios with literal
// expectations.
module tb_bitty_fetch_unit;

    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int TMO      = 15;
    localparam int CORE_LAT = 3;
    localparam int HOLD     = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] instruction;
    logic          run;
    logic          done;
    logic [AW:0]   pc;
    logic [15:0]   instr_count;
    logic          busy, halted, error;

    always #5 clk = ~clk;

    bitty_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .instruction (instruction),
        .run         (run),
        .done        (done),
        .pc          (pc),
        .instr_count (instr_count),
        .busy        (busy),
        .halted      (halted),
        .error       (error)
    );

    // Core model: done in the CORE_LAT-th cycle of run; optionally held
    // high for HOLD more cycles after completion.
    logic core_en = 1'b1;
    logic hold_en = 1'b0;
    int   run_age = 0;
    int   hold_cnt = 0;

    assign done = (core_en && run === 1'b1 && run_age == CORE_LAT - 1) || (hold_cnt > 0);

    always @(posedge clk) begin
        if (run === 1'b1) run_age <= run_age + 1;
        else              run_age <= 0;
        if (hold_en && core_en && run === 1'b1 && run_age == CORE_LAT - 1) hold_cnt <= HOLD;
        else if (hold_cnt > 0)                                              hold_cnt <= hold_cnt - 1;
    end

    // Transaction model: instructions retired = handshakes (run && done)
    // since the last start/reset; pc and instr_count must both equal it.
    logic [DW-1:0] m_mem [0:2**AW-1];
    int            m_ret = 0;
    int            m_rises = 0;
    logic          prev_run = 1'b0;

    always @(posedge clk) begin
        prev_run <= (run === 1'b1);
        if (reset || (start && !stop)) begin
            m_ret   <= 0;
            m_rises <= 0;
        end else begin
            if (run === 1'b1 && done) m_ret <= m_ret + 1;
            if (run === 1'b1 && !prev_run) m_rises <= m_rises + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare process.
    logic chk_en = 1'b0;
    int   run_len = 0;
    logic neg_prev_run = 1'b0;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("pc_track", 32'(pc), 32'(m_ret));
            chk("count_track", 32'(instr_count), 32'(m_ret));
            chk("status_excl", 32'((busy & halted) | (busy & error) | (halted & error)), 32'd0);
            if (run === 1'b1) begin
                run_len++;
                chk("instr_track", 32'(instruction), 32'(m_mem[m_ret[AW-1:0]]));
                chk("run_bound", 32'(run_len <= TMO), 32'd1);
                if (!neg_prev_run) chk("done_low_at_issue", 32'(hold_cnt), 32'd0);
            end else begin
                run_len = 0;
            end
        end
        neg_prev_run = (run === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic model);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        if (model) m_mem[a] = d;
    endtask

    // Returns at the negedge after the edge that samples start.
    task automatic start_prog(input logic [AW:0] len);
        @(negedge clk);
        prog_len = len;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_issue_of(input int idx, input string name);
        int n;
        n = 0;
        while (!(run === 1'b1 && m_ret == idx) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(run === 1'b1 && m_ret == idx), 32'd1);
    endtask

    initial begin
        int hi;
        int n;

        tick(2);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: three-instruction program
        load(8'd0, 16'h1234, 1'b1);
        load(8'd1, 16'h2468, 1'b1);
        load(8'd2, 16'h0001, 1'b1);
        load(8'd3, 16'hABCD, 1'b1);
        load(8'd4, 16'h5555, 1'b1);
        start_prog(9'd3);
        chk("t1_fetch_busy", 32'(busy), 32'd1);
        chk("t1_fetch_norun", 32'(run), 32'd0);
        @(negedge clk);
        chk("t1_run_2_edges", 32'(run), 32'd1);
        chk("t1_first_instr", 32'(instruction), 32'h1234);
        wait_halt("t1_halt", 200);
        chk("t1_count", 32'(instr_count), 32'd3);
        chk("t1_pc", 32'(pc), 32'd3);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_pulses", 32'(m_rises), 32'd3);

        // 2: empty program halts immediately
        start_prog(9'd0);
        chk("t2_halt", 32'(halted), 32'd1);
        chk("t2_norun", 32'(run), 32'd0);
        chk("t2_count", 32'(instr_count), 32'd0);
        tick(3);
        chk("t2_pulses", 32'(m_rises), 32'd0);

        // 3: stop during second ISSUE
        start_prog(9'd5);
        wait_issue_of(1, "t3_second_issue");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_halt("t3_halt", 200);
        chk("t3_pc", 32'(pc), 32'd2);
        chk("t3_count", 32'(instr_count), 32'd2);
        chk("t3_pulses", 32'(m_rises), 32'd2);

        // 4: core never answers -> timeout, then restart
        core_en = 1'b0;
        start_prog(9'd3);
        hi = 0;
        n  = 0;
        while (error !== 1'b1 && n < 100) begin
            if (run === 1'b1) hi++;
            @(negedge clk);
            n++;
        end
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_run_cycles", 32'(hi), 32'd15);
        chk("t4_run_low", 32'(run), 32'd0);
        chk("t4_pc", 32'(pc), 32'd0);
        core_en = 1'b1;
        start_prog(9'd3);
        chk("t4_error_clr", 32'(error), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t4_reissue", 32'(instruction), 32'h1234);
        wait_halt("t4_halt", 200);
        chk("t4_count", 32'(instr_count), 32'd3);

        // 5: level-held done counted once
        hold_en = 1'b1;
        start_prog(9'd3);
        wait_halt("t5_halt", 300);
        chk("t5_count", 32'(instr_count), 32'd3);
        chk("t5_pc", 32'(pc), 32'd3);
        chk("t5_pulses", 32'(m_rises), 32'd3);
        hold_en = 1'b0;
        tick(6);

        // 6: load while busy is ignored; reset mid-ISSUE
        start_prog(9'd3);
        wait_issue_of(1, "t6_second_issue");
        load_en   = 1'b1;
        load_addr = 8'd0;
        load_data = 16'hDEAD;
        @(negedge clk);
        load_en = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk("t6_run", 32'(run), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
        chk("t6_count", 32'(instr_count), 32'd0);
        chk("t6_idle", 32'({busy, halted, error}), 32'd0);
        reset = 1'b0;
        start_prog(9'd3);
        @(negedge clk);
        chk("t6_run_again", 32'(run), 32'd1);
        chk("t6_mem_kept", 32'(instruction), 32'h1234);
        wait_halt("t6_halt", 200);
        chk("t6_final_count", 32'(instr_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
